ysyx_23060332_lsu: RTL

YSYX_23060332_LSU -- requirements
Module: ysyx_23060332_lsu

---
 rtl/ysyx_23060332_lsu_pkg.sv | 74 +++++++
 rtl/ysyx_23060332_lsu_ext.sv | 25 ++
 rtl/ysyx_23060332_lsu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_lsu_pkg.sv
// ysyx_23060332_lsu_pkg
// Shared definitions for the load/store unit:
//   - FSM state encoding (lsu_state_e)
//   - funct3 encodings for LB/LH/LW/LBU/LHU and SB/SH/SW
//   - write-mask constants and access-size helpers
// Imported by ysyx_23060332_lsu and ysyx_23060332_lsu_ext.
package ysyx_23060332_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // funct3 encodings (loads use all five, stores use B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;

    // op = {store, funct3}. Any encoding that is not a defined byte or
    // halfword access is treated as a word access.
    function automatic lsu_size_e op_size(input logic [3:0] op);
        lsu_size_e sz;
        sz = SZ_W;
        if (op[3]) begin
            case (op[2:0])
                F3_B:    sz = SZ_B;
                F3_H:    sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            case (op[2:0])
                F3_B, F3_BU: sz = SZ_B;
                F3_H, F3_HU: sz = SZ_H;
                default:     sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    function automatic logic [7:0] size_mask(input lsu_size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = MASK_B;
            SZ_H:    m = MASK_H;
            default: m = MASK_W;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lsb);
        logic mis;
        case (sz)
            SZ_H:    mis = lsb[0];
            SZ_W:    mis = |lsb;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_ext.sv
// ysyx_23060332_lsu_ext
// Combinational load-data extension.
//   funct3 : load funct3 (LB/LH/LW/LBU/LHU; anything else passes raw through)
//   raw    : 32-bit word returned by memory
//   result : sign/zero-extended load result
module ysyx_23060332_lsu_ext
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (funct3)
            F3_B:    result = {{24{raw[7]}}, raw[7:0]};
            F3_H:    result = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   result = {24'd0, raw[7:0]};
            F3_HU:   result = {16'd0, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu
// Load/store unit between EXU and WBU with a fixed-latency memory port.
// Flow: IDLE -> (WAIT x LAT_CYCLES) -> ACCESS -> RESP -> IDLE.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready. The LSU raises in_ready only in IDLE and captures the
// request on that edge, so upstream may drop its inputs afterwards. In RESP
// out_valid stays high and out_rdata/out_rd/out_fault are held until the
// edge on which out_ready is also high.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              upstream handshake
//   in_op/in_addr/in_wdata/in_rd   request ({store, funct3}, address, data, rd)
//   out_valid/out_ready            downstream handshake
//   out_rdata/out_rd/out_fault     response
//   mem_ren/mem_raddr/mem_rdata    read port (data sampled in ACCESS)
//   mem_wen/mem_waddr/mem_wdata/mem_wmask  write port
//   dbg_state                      current FSM state
//
// Parameter LAT_CYCLES (0..15): wait cycles between accept and ACCESS.
// Macro YSYX_23060332_LSU_MISALIGN_TRAP_EN: when defined, misaligned
// halfword/word accesses go straight to RESP with out_fault=1 and never
// touch memory; otherwise they are passed to memory unchanged.
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int unsigned LAT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_fault,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] LAT = 4'(LAT_CYCLES);

    lsu_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] ext_result;
    logic        accept_fault;
    logic        in_access;

    ysyx_23060332_lsu_ext u_ext (
        .funct3 (op_q[2:0]),
        .raw    (mem_rdata),
        .result (ext_result)
    );

`ifdef YSYX_23060332_LSU_MISALIGN_TRAP_EN
    assign accept_fault = is_misaligned(op_size(in_op), in_addr[1:0]);
`else
    assign accept_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        addr_q  <= in_addr;
                        wdata_q <= in_wdata;
                        rd_q    <= in_rd;
                        cnt_q   <= LAT;
                        fault_q <= accept_fault;
                        if (accept_fault) begin
                            // Trapped access: respond immediately, no strobe.
                            rdata_q <= 32'd0;
                            state_q <= ST_RESP;
                        end else if (LAT == 4'd0) begin
                            state_q <= ST_ACCESS;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= op_q[3] ? 32'd0 : ext_result;
                    cnt_q   <= 4'd0;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register, so an async reset
    // drops them in the same instant the state returns to IDLE.
    assign in_access = (state_q == ST_ACCESS);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RESP);
    assign out_rdata = rdata_q;
    assign out_rd    = rd_q;
    assign out_fault = fault_q;

    assign mem_ren   = in_access && !op_q[3];
    assign mem_wen   = in_access && op_q[3];
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = mem_wen ? size_mask(op_size(op_q)) : 8'h00;

    assign dbg_state = state_q;

endmodule
